// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
// Shared constants and helpers for the FIFO read-side stream master.
// Holds the depth of the skid buffer, the width of its pointers and
// occupancy count, and the pointer advance function that wraps at the
// buffer depth (which is not a power of two).
package fifo_stream_pkg;

  // Three entries cover the word in the buffer head, one more waiting
  // behind it, and the word still travelling out of the FIFO.
  localparam int BUF_DEPTH = 3;
  localparam int OCC_WIDTH = 2;

  typedef logic [OCC_WIDTH-1:0] ptr_t;

  // Advance a buffer pointer, wrapping from the last entry back to 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf
// Three-entry circular skid buffer that absorbs words arriving from the
// FIFO while the downstream consumer is stalled.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   wr        - write the incoming word this cycle (FIFO read data is valid)
//   wdata     - incoming word
//   rd        - the head word is consumed this cycle
//   rdata     - head word (entry at the read pointer)
//   occ       - number of words held, 0..3
module fifo_rd_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [OCC_WIDTH-1:0]  occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;

  // The head entry is always presented, valid or not; the top level only
  // qualifies it with occ. Storage is cleared on reset so nothing from
  // before a reset can ever be shown again.
  assign rdata = mem[rd_ptr];

  // Storage and write pointer: a word is written whenever one arrives.
  // The pop rule upstream guarantees there is always a free slot for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= ptr_inc(wr_ptr);
    end
  end

  // Read pointer and occupancy. A simultaneous write and read leaves the
  // count unchanged, which is the steady state at full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr, rd})
        2'b10:   occ <= occ + OCC_WIDTH'(1);
        2'b01:   occ <= occ - OCC_WIDTH'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side master for the synchronous FIFO. Pops words, absorbs the
// FIFO's one-cycle read latency in a small skid buffer, and presents the
// words on a valid/ready stream with m_last marking every BURST_LEN-th word.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   en          - allows new pops; in-flight data is still captured
//   fifo_empty  - FIFO empty flag
//   fifo_data   - FIFO read data, valid the cycle after a pop
//   fifo_r_en   - pop request to the FIFO
//   m_valid     - stream word valid
//   m_data      - stream word
//   m_last      - last word of the current burst
//   m_ready     - downstream accept
//   word_count  - words accepted downstream since reset (wrapping)
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int                    BEAT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_WIDTH-1:0] BEAT_MAX   = BEAT_WIDTH'(BURST_LEN - 1);

  logic                  inflight;
  logic [OCC_WIDTH-1:0]  occ;
  logic [OCC_WIDTH:0]    pending;
  logic                  transfer;
  logic [BEAT_WIDTH-1:0] beat;

  // Words already committed to the buffer: those held plus the one still
  // coming out of the FIFO. A new pop is allowed only while a slot remains
  // for it. Only registered state and FIFO flags feed this, so m_ready has
  // no combinational path to the pop. Reset holds the pop low so the FIFO
  // is not drained while this block is being cleared.
  assign pending   = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight};
  assign fifo_r_en = ~rst & en & ~fifo_empty & (pending <= (OCC_WIDTH + 1)'(BUF_DEPTH - 1));

  assign m_valid  = (occ != '0);
  assign transfer = m_valid & m_ready;
  assign m_last   = m_valid & (beat == BEAT_MAX);

  // A pop issued this cycle means the FIFO presents data next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
    end
  end

  // Burst position advances only on accepted words, so it survives gaps
  // where the FIFO runs dry or the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (transfer) begin
      beat <= (beat == BEAT_MAX) ? '0 : beat + BEAT_WIDTH'(1);
    end
  end

  // Running total of accepted words, wrapping naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (transfer) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (inflight),
    .wdata(fifo_data),
    .rd   (transfer),
    .rdata(m_data),
    .occ  (occ)
  );

endmodule
